// File: rtl/projection_scheduler.sv
// projection_scheduler: shares one projection engine between the R, G and B
// threshold channels. Grants are round-robin and aligned to frame boundaries.
// The engine stays enabled for a fixed number of frames. Its bounding box is
// then captured into the channel's slot. A quiet gap follows each grant so the
// engine can clear its projection RAMs.
module projection_scheduler #(
  parameter int FRAMES_PER_GRANT = 5,
  parameter int GAP_CYCLES       = 1040
) (
  input  logic          pixelclk,
  input  logic          reset,
  input  logic          i_vs,
  input  logic [2:0]    i_req,
  input  logic [11:0]   i_hcount_l,
  input  logic [11:0]   i_hcount_r,
  input  logic [11:0]   i_vcount_l,
  input  logic [11:0]   i_vcount_r,
  output logic          o_en,
  output logic [1:0]    o_sel,
  output logic [2:0]    o_grant,
  output logic [143:0]  o_box,
  output logic [2:0]    o_box_valid,
  output logic [2:0]    o_box_err,
  output logic          o_busy
);

  localparam int                GAP_W        = $clog2(GAP_CYCLES + 1);
  localparam logic [GAP_W-1:0]  GAP_LAST     = GAP_W'(GAP_CYCLES - 1);
  localparam logic [2:0]        FRAME_TARGET = 3'(FRAMES_PER_GRANT);

  typedef enum logic [2:0] {IDLE, ARB, ARM, RUN, CAPTURE, GAP} state_t;

  state_t             state_reg, state_next;
  logic [1:0]         last_reg, last_next;
  logic [1:0]         sel_reg, sel_next;
  logic [2:0]         grant_reg, grant_next;
  logic [2:0]         frame_cnt_reg, frame_cnt_next;
  logic [GAP_W-1:0]   gap_cnt_reg, gap_cnt_next;
  logic               vs_d_reg;
  logic               fall_reg;
  logic [2:0]         box_valid_reg, box_valid_next;
  logic [2:0]         box_err_reg, box_err_next;
  logic               box_we;

  logic               rr_found;
  logic [1:0]         rr_ch;
  logic [1:0]         rr_cand;
  logic               req_granted;
  logic               box_ok;
  logic [2:0]         frame_cnt_inc;

  // Granted channel still requesting; losing it aborts the grant.
  assign req_granted   = |(i_req & grant_reg);
  // Unsigned comparison: a degenerate or inverted box is rejected.
  assign box_ok        = (i_hcount_r > i_hcount_l) && (i_vcount_r > i_vcount_l);
  assign frame_cnt_inc = frame_cnt_reg + 3'd1;

  // Round-robin search starting at the channel after the last grant.
  always_comb begin
    rr_found = 1'b0;
    rr_ch    = last_reg;
    rr_cand  = last_reg;
    for (int i = 0; i < 3; i++) begin
      rr_cand = (rr_cand == 2'd2) ? 2'd0 : rr_cand + 2'd1;
      if (!rr_found && i_req[rr_cand]) begin
        rr_found = 1'b1;
        rr_ch    = rr_cand;
      end
    end
  end

  // Frame-edge detection: i_vs registered once, falling edge registered again.
  always_ff @(posedge pixelclk) begin
    if (reset) begin
      vs_d_reg <= 1'b0;
      fall_reg <= 1'b0;
    end else begin
      vs_d_reg <= i_vs;
      fall_reg <= !i_vs && vs_d_reg;
    end
  end

  // Next-state logic for the grant sequence and its counters.
  always_comb begin
    state_next     = state_reg;
    last_next      = last_reg;
    sel_next       = sel_reg;
    grant_next     = grant_reg;
    frame_cnt_next = frame_cnt_reg;
    gap_cnt_next   = gap_cnt_reg;
    box_we         = 1'b0;
    box_valid_next = 3'b000;
    box_err_next   = 3'b000;
    case (state_reg)
      IDLE: begin
        if (|i_req) state_next = ARB;
      end
      ARB: begin
        if (rr_found) begin
          grant_next = 3'b001 << rr_ch;
          sel_next   = rr_ch;
          last_next  = rr_ch;
          state_next = ARM;
        end else begin
          state_next = IDLE;
        end
      end
      ARM: begin
        // Abort has priority over a coincident frame edge.
        if (!req_granted) begin
          grant_next   = 3'b000;
          gap_cnt_next = '0;
          state_next   = GAP;
        end else if (fall_reg) begin
          frame_cnt_next = 3'd0;
          state_next     = RUN;
        end
      end
      RUN: begin
        if (!req_granted) begin
          grant_next   = 3'b000;
          gap_cnt_next = '0;
          state_next   = GAP;
        end else if (fall_reg) begin
          frame_cnt_next = frame_cnt_inc;
          if (frame_cnt_inc == FRAME_TARGET) state_next = CAPTURE;
        end
      end
      CAPTURE: begin
        // Engine is disabled this cycle; its box outputs are stable.
        if (box_ok) begin
          box_we         = 1'b1;
          box_valid_next = grant_reg;
        end else begin
          box_err_next   = grant_reg;
        end
        grant_next   = 3'b000;
        gap_cnt_next = '0;
        state_next   = GAP;
      end
      GAP: begin
        if (gap_cnt_reg == GAP_LAST) begin
          gap_cnt_next = '0;
          state_next   = ARB;
        end else begin
          gap_cnt_next = gap_cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and control registers; last starts at B so the first grant goes to R.
  always_ff @(posedge pixelclk) begin
    if (reset) begin
      state_reg     <= IDLE;
      last_reg      <= 2'd2;
      sel_reg       <= 2'd0;
      grant_reg     <= 3'b000;
      frame_cnt_reg <= 3'd0;
      gap_cnt_reg   <= '0;
      box_valid_reg <= 3'b000;
      box_err_reg   <= 3'b000;
    end else begin
      state_reg     <= state_next;
      last_reg      <= last_next;
      sel_reg       <= sel_next;
      grant_reg     <= grant_next;
      frame_cnt_reg <= frame_cnt_next;
      gap_cnt_reg   <= gap_cnt_next;
      box_valid_reg <= box_valid_next;
      box_err_reg   <= box_err_next;
    end
  end

  // One result slot per channel, packed {hl, hr, vl, vr} with hl in the MSBs.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_slot
      logic [47:0] slot_reg;
      // Slot captures the engine box only on a valid capture for this channel.
      always_ff @(posedge pixelclk) begin
        if (reset) begin
          slot_reg <= 48'd0;
        end else if (box_we && grant_reg[gi]) begin
          slot_reg <= {i_hcount_l, i_hcount_r, i_vcount_l, i_vcount_r};
        end
      end
      assign o_box[48*gi +: 48] = slot_reg;
    end
  endgenerate

  assign o_en        = (state_reg == RUN);
  assign o_busy      = (state_reg != IDLE);
  assign o_sel       = sel_reg;
  assign o_grant     = grant_reg;
  assign o_box_valid = box_valid_reg;
  assign o_box_err   = box_err_reg;

endmodule

// File: tb/tb_projection_scheduler.sv
// Scoreboard bench for projection_scheduler: the driver predicts each grant and
// its outcome from round-robin and box rules, a monitor checks DUT events.
module tb_projection_scheduler;

  localparam int FPG = 5;
  localparam int GAP = 1040;
  localparam int NF  = FPG + 1;   // one arming edge plus FPG counted edges

  localparam int K_GRANT = 0;
  localparam int K_VALID = 1;
  localparam int K_ERR   = 2;
  localparam int K_NONE  = 3;

  typedef struct {
    int            kind;
    int            ch;
    logic [143:0]  box;
  } ev_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          i_vs = 1'b0;
  logic [2:0]    i_req = 3'b000;
  logic [11:0]   i_hcount_l = '0, i_hcount_r = '0, i_vcount_l = '0, i_vcount_r = '0;
  logic          o_en;
  logic [1:0]    o_sel;
  logic [2:0]    o_grant;
  logic [143:0]  o_box;
  logic [2:0]    o_box_valid, o_box_err;
  logic          o_busy;

  ev_t           q[$];
  logic [47:0]   model_box [3];
  int            model_last;
  int            n_checks = 0;
  int            n_fail = 0;
  int            cyc = 0;
  bit            stop = 1'b0;
  bit            mon_on = 1'b0;
  bit            hold_busy = 1'b0;

  projection_scheduler #(.FRAMES_PER_GRANT(FPG), .GAP_CYCLES(GAP)) dut (
    .pixelclk(clk), .reset(reset), .i_vs(i_vs), .i_req(i_req),
    .i_hcount_l(i_hcount_l), .i_hcount_r(i_hcount_r),
    .i_vcount_l(i_vcount_l), .i_vcount_r(i_vcount_r),
    .o_en(o_en), .o_sel(o_sel), .o_grant(o_grant), .o_box(o_box),
    .o_box_valid(o_box_valid), .o_box_err(o_box_err), .o_busy(o_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_box(input string name, input logic [143:0] act, input logic [143:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s actual=timeout required=event (t=%0t)", name, $time);
    stop = 1'b1;
  endtask

  function automatic logic [143:0] model_o_box();
    return {model_box[2], model_box[1], model_box[0]};
  endfunction

  task automatic gen_box(output logic [11:0] hl, output logic [11:0] hr,
                         output logic [11:0] vl, output logic [11:0] vr);
    logic [11:0] a, b, c, d, t;
    a = 12'($urandom_range(0, 4095)); b = 12'($urandom_range(0, 4095));
    c = 12'($urandom_range(0, 4095)); d = 12'($urandom_range(0, 4095));
    if ($urandom_range(0, 9) == 0) b = a;
    if ($urandom_range(0, 9) == 0) d = c;
    if ($urandom_range(0, 3) != 0 && a > b) begin t = a; a = b; b = t; end
    if ($urandom_range(0, 3) != 0 && c > d) begin t = c; c = d; d = t; end
    hl = a; hr = b; vl = c; vr = d;
  endtask

  task automatic do_reset();
    reset = 1'b1; i_req = 3'b000; i_vs = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    model_last = 2;
    for (int k = 0; k < 3; k++) model_box[k] = 48'd0;
  endtask

  // One grant. mode 0 = run to capture, 1 = drop request after fall drop_at
  // (0 = before any frame), 2 = assert reset during RUN.
  task automatic txn(input logic [2:0] mask, input logic [11:0] hl, input logic [11:0] hr,
                     input logic [11:0] vl, input logic [11:0] vr, input int mode,
                     input int drop_at, input bit chk_lat, input bit gap_chk);
    int   c;
    int   n;
    int   en_lat;
    int   pulse_lat;
    int   pulse_cyc;
    bit   en_seen;
    bit   box_good;
    ev_t  e;
    if (stop) return;
    c = -1;
    for (int i = 1; i <= 3; i++) begin
      if (c < 0 && mask[(model_last + i) % 3]) c = (model_last + i) % 3;
    end
    model_last = c;
    e.kind = K_GRANT; e.ch = c; e.box = '0;
    q.push_back(e);
    i_hcount_l = hl; i_hcount_r = hr; i_vcount_l = vl; i_vcount_r = vr;
    i_req = mask;
    n = 0;
    while (o_grant == 3'b000 && n < 3000) begin tick(); n++; end
    if (o_grant == 3'b000) begin timeout("grant_wait"); return; end
    if (chk_lat) check_int("grant_latency", n, 2);
    box_good = (hr > hl) && (vr > vl);
    e.ch = c;
    if (mode == 0) begin
      if (box_good) model_box[c] = {hl, hr, vl, vr};
      e.kind = box_good ? K_VALID : K_ERR;
      e.box  = model_o_box();
    end else if (mode == 1) begin
      e.kind = K_NONE;
      e.box  = model_o_box();
    end else begin
      e.kind = K_NONE;
      e.box  = '0;
    end
    q.push_back(e);
    pulse_cyc = 0;
    if (mode == 1 && drop_at == 0) begin
      i_req = mask & ~(3'b001 << c);
      tick();
      check_int("abort_en", int'(o_en), 0);
      check_int("abort_grant", int'(o_grant), 0);
    end else begin
      for (int f = 1; f <= NF; f++) begin
        i_vs = 1'b1;
        repeat ($urandom_range(2, 4)) tick();
        i_vs = 1'b0;
        if (mode == 1 && f == drop_at) begin
          i_req = mask & ~(3'b001 << c);
          tick();
          check_int("abort_en", int'(o_en), 0);
          check_int("abort_grant", int'(o_grant), 0);
          break;
        end
        en_lat = -1; pulse_lat = -1;
        for (int t = 1; t <= 5; t++) begin
          tick();
          if (f == 1 && o_en && en_lat < 0) en_lat = t;
          if (f == NF && (o_box_valid | o_box_err) != 3'b000 && pulse_lat < 0) begin
            pulse_lat = t;
            pulse_cyc = cyc;
          end
        end
        if (f == 1) check_int("en_latency", en_lat, 2);
        if (f == NF) check_int("capture_latency", pulse_lat, 3);
        if (mode == 2 && f == 3) begin
          reset = 1'b1; i_req = 3'b000;
          tick();
          check_int("rst_en", int'(o_en), 0);
          check_int("rst_sel", int'(o_sel), 0);
          check_int("rst_grant", int'(o_grant), 0);
          check_box("rst_box", o_box, '0);
          check_int("rst_pulses", int'(o_box_valid | o_box_err), 0);
          check_int("rst_busy", int'(o_busy), 0);
          reset = 1'b0;
          model_last = 2;
          for (int k = 0; k < 3; k++) model_box[k] = 48'd0;
          break;
        end
      end
    end
    n = 0;
    while (o_grant != 3'b000 && n < 100) begin tick(); n++; end
    if (o_grant != 3'b000) begin timeout("grant_release"); return; end
    if (gap_chk) begin
      i_req = 3'b000;
      en_seen = 1'b0;
      n = 0;
      while (o_busy && n < 5000) begin
        if (o_en) en_seen = 1'b1;
        tick();
        n++;
      end
      if (o_busy) begin timeout("idle_wait"); return; end
      // Busy without a grant covers the GAP cycles plus the final ARB cycle.
      check_int("gap_length", cyc - pulse_cyc, GAP + 1);
      check_int("gap_en_low", int'(en_seen), 0);
      en_seen = 1'b0;
      repeat (50) begin
        tick();
        if (o_en || o_busy) en_seen = 1'b1;
      end
      check_int("idle_quiet", int'(en_seen), 0);
    end
  endtask

  // Monitor: pops the scoreboard whenever a grant starts or ends.
  initial begin
    logic [2:0] prev_grant;
    logic [2:0] pulses;
    bit         rose, fell;
    int         act_kind;
    ev_t        e;
    prev_grant = 3'b000;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        pulses = o_box_valid | o_box_err;
        rose = (prev_grant == 3'b000) && (o_grant != 3'b000);
        fell = (prev_grant != 3'b000) && (o_grant == 3'b000);
        check_int("grant_onehot", ($countones(o_grant) <= 1) ? 1 : 0, 1);
        check_int("valid_err_excl", int'(o_box_valid & o_box_err), 0);
        if (!fell) check_int("stray_pulse", int'(pulses), 0);
        if (hold_busy) check_int("busy_hold", int'(o_busy), 1);
        if (rose || fell) begin
          if (q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL scoreboard_empty actual=grant_event required=none (t=%0t)", $time);
          end else begin
            e = q.pop_front();
            if (rose) begin
              check_int("grant_kind", K_GRANT, e.kind);
              check_int("grant_ch", int'(o_grant), 1 << e.ch);
              check_int("grant_sel", int'(o_sel), e.ch);
            end else begin
              act_kind = (o_box_valid != 3'b000) ? K_VALID :
                         (o_box_err != 3'b000) ? K_ERR : K_NONE;
              check_int("end_kind", act_kind, e.kind);
              if (e.kind != K_NONE) check_int("pulse_ch", int'(pulses), 1 << e.ch);
              check_box("box_slots", o_box, e.box);
            end
          end
        end
        prev_grant = o_grant;
      end
    end
  end

  initial begin
    logic [11:0] hl, hr, vl, vr;
    int          mode, drop_at;
    model_last = 2;
    for (int k = 0; k < 3; k++) model_box[k] = 48'd0;
    do_reset();
    reset = 1'b1;
    tick();
    check_int("reset_en", int'(o_en), 0);
    check_int("reset_sel", int'(o_sel), 0);
    check_int("reset_grant", int'(o_grant), 0);
    check_box("reset_box", o_box, '0);
    check_int("reset_valid", int'(o_box_valid), 0);
    check_int("reset_err", int'(o_box_err), 0);
    check_int("reset_busy", int'(o_busy), 0);
    reset = 1'b0;
    mon_on = 1'b1;

    // First grant to R with a known box, then a measured gap back to IDLE.
    txn(3'b001, 12'd100, 12'd300, 12'd50, 12'd200, 0, 0, 1'b1, 1'b1);
    check_box("slot0_known", {96'd0, o_box[47:0]}, {96'd0, 48'h064_12C_032_0C8});

    // All three requesting: R, G, B, R, then G aborts, B, then R rejects.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      gen_box(hl, hr, vl, vr);
      hr = (hl == 12'hFFF) ? hl : hl + 12'(1 + $urandom_range(0, 400));
      vr = (vl == 12'hFFF) ? vl : vl + 12'(1 + $urandom_range(0, 400));
      txn(3'b111, hl, hr, vl, vr, 0, 0, 1'b0, 1'b0);
      hold_busy = 1'b1;
    end
    gen_box(hl, hr, vl, vr);
    txn(3'b111, hl, hr, vl, vr, 1, 3, 1'b0, 1'b0);
    txn(3'b111, 12'd10, 12'd20, 12'd30, 12'd40, 0, 0, 1'b0, 1'b0);
    txn(3'b111, 12'd300, 12'd100, 12'd50, 12'd200, 0, 0, 1'b0, 1'b0);
    hold_busy = 1'b0;

    // Reset during RUN, then a lone G request from IDLE.
    txn(3'b001, 12'd1, 12'd2, 12'd3, 12'd4, 2, 0, 1'b0, 1'b0);
    txn(3'b010, 12'd0, 12'd4095, 12'd0, 12'd4095, 0, 0, 1'b1, 1'b0);

    // Randomized grants with occasional aborts at any frame edge.
    for (int k = 0; k < 22; k++) begin
      gen_box(hl, hr, vl, vr);
      mode = ($urandom_range(0, 9) < 2) ? 1 : 0;
      drop_at = $urandom_range(0, NF);
      txn(3'($urandom_range(1, 7)), hl, hr, vl, vr, mode, drop_at, 1'b0, 1'b0);
    end

    // Last grant, then requests withdrawn: back to IDLE and quiet.
    gen_box(hl, hr, vl, vr);
    txn(3'($urandom_range(1, 7)), hl, hr, vl, vr, 0, 0, 1'b0, 1'b1);

    repeat (5) tick();
    check_int("scoreboard_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
